hd44780_bus_sched: RTL and testbench
====================================

// Module: hd44780_bus_sched
// PURPOSE
//  Shares one HD44780 8-bit write-only bus between two requesters (e.g. init-sequence
//  walker and text refresher). Enforces power-up delay, round-robin arbitration,
//  RS/data setup, E (lcd_clk) low pulse and per-transfer completion wait.
//  Sits between the LCD sequencers and the top-level LCD pins, 1 MHz clock domain.
// PARAMETERS
//  POWERUP_CYC  15000  cycles after reset before first transfer (15 ms at 1 MHz)
//  SETUP_CYC    1      cycles RS/data stable with lcd_clk high before pulse (>=1)
//  PULSE_CYC    2      cycles lcd_clk held low (>=1)
//  MIN_WAIT     40     floor on post-pulse wait cycles
// PORTS
//  clk           in   1   system clock, 1 MHz; all logic on negedge clk
//  rst           in   1   synchronous reset, active-high
//  req           in   2   per-requester transfer request, held until grant
//  req_rs        in   2   per-requester RS (0 command, 1 data)
//  req_data      in   16  per-requester byte, [8i+7:8i] for requester i
//  req_wait      in   32  per-requester post-pulse wait cycles, [16i+15:16i]
//  grant         out  2   one-cycle pulse: request i accepted, inputs captured
//  done          out  2   one-cycle pulse: transfer i finished, bus free next cycle
//  busy          out  1   1 in every state except IDLE
//  lcd_rs        out  1   LCD register select
//  lcd_rw        out  1   LCD read/write, constant 0
//  lcd_clk       out  1   LCD enable, idle high, low during strobe
//  lcd_data      out  8   LCD data bus
// BEHAVIOUR
//  - Reset values: grant=0, done=0, busy=1, lcd_rs=0, lcd_rw=0, lcd_clk=1, lcd_data=8'h00,
//    state=POWERUP, counter=0, rr pointer=0 (requester 0 preferred first).
//  - POWERUP: count POWERUP_CYC cycles, req ignored, no grant; then IDLE.
//  - IDLE: if any req, pick winner; grant[w]=1 this cycle; capture rs/data/wait of w;
//    lcd_rs/lcd_data take captured values on the same edge; go SETUP. No req: stay.
//  - Arbitration: only one req -> it wins. Both -> the one not served last wins;
//    pointer updates at grant only. Strict alternation under continuous contention.
//  - SETUP: SETUP_CYC cycles, lcd_clk=1; then STROBE.
//  - STROBE: lcd_clk=0 for exactly PULSE_CYC cycles; returns to 1 on exit; then WAIT.
//  - WAIT: lcd_clk=1, hold lcd_rs/lcd_data; count W=max(captured wait, MIN_WAIT)
//    cycles; last WAIT cycle asserts done[w]; next state IDLE.
//  - Grant-to-done spacing: exactly SETUP_CYC+PULSE_CYC+W cycles; next grant no earlier
//    than the cycle after done. Minimum period per transfer = 1+SETUP_CYC+PULSE_CYC+W.
//  - lcd_rs/lcd_data change only at grant edges; stable through SETUP/STROBE/WAIT.
//  - req inputs sampled only in IDLE; changes during a transfer are ignored.
//    req dropped before grant -> never served, no side effects.
//  - Requester asserting req in the same cycle as its own done is eligible next IDLE.
//  - Wait width 16 bits; 0..MIN_WAIT-1 all yield MIN_WAIT; 16'hFFFF honoured exactly.
//  - Counter 16 bits, saturation impossible with legal parameters (all < 65536).
//  - rst mid-transfer: all outputs to reset values next edge (lcd_clk forced high,
//    pulse truncated), pending grant/done lost, full POWERUP delay repeated.
//  - grant and done never both asserted in one cycle; at most one bit of each set.
// STRUCTURE
//  - hd44780_defs.vh: state encodings (POWERUP, IDLE, SETUP, STROBE, WAIT), default
//    timing constants shared with other hd44780_* blocks.
//  - Sub-module hd44780_rr_arb: 2-way round-robin, inputs req[1:0]+pointer, outputs
//    one-hot winner; combinational, pointer register kept in parent.
//  - One FSM + one 16-bit down-counter in parent; no other sub-modules.
// TESTING
//  - Reset, req=2'b11 held -> no grant for 15000 cycles, first grant[0] at cycle 15001.
//  - req0 only, rs=0, data=8'h38, wait=37 -> lcd_data=8'h38, lcd_clk low 2 cycles,
//    done[0] exactly 1+2+40 cycles after grant (wait floored to MIN_WAIT).
//  - Both req continuously, wait=100 each -> grants alternate 0,1,0,1; spacing 104.
//  - req1 with rs=1, data=8'h41, wait=16'hFFFF -> done[1] 65538 cycles after grant;
//    lcd_rs=1 and data stable throughout.
//  - Assert rst during STROBE -> next edge lcd_clk=1, lcd_data=8'h00, busy=1; no done;
//    following grant only after another 15000-cycle POWERUP.
//  - req0 pulsed 1 cycle during WAIT of requester 1 and dropped -> never granted.

Source files
------------

// File: rtl/hd44780_bus_sched_pkg.sv
// Shared definitions for the hd44780_* blocks.
// Contents: FSM state encodings, default bus timing constants and a helper that
// applies the minimum post-pulse wait to a requested wait count.
package hd44780_bus_sched_pkg;

    localparam logic [2:0] ST_POWERUP = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_SETUP   = 3'd2;
    localparam logic [2:0] ST_STROBE  = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;

    // Default timing in 1 MHz cycles.
    localparam int unsigned DEF_POWERUP_CYC = 15000;
    localparam int unsigned DEF_SETUP_CYC   = 1;
    localparam int unsigned DEF_PULSE_CYC   = 2;
    localparam int unsigned DEF_MIN_WAIT    = 40;

    // Requested waits below the floor are raised to the floor; larger ones pass through.
    function automatic logic [15:0] wait_floor(input logic [15:0] w, input logic [15:0] min_w);
        return (w < min_w) ? min_w : w;
    endfunction

endpackage

// File: rtl/hd44780_rr_arb.sv
// 2-way round-robin arbiter (combinational).
// Ports:
//   req_i [1:0]  request per requester
//   ptr_i        requester preferred when both request
//   win_o [1:0]  one-hot winner, zero when no request
// The pointer register lives in the parent so it only moves on an actual grant.
module hd44780_rr_arb (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] win_o
);

    always_comb begin
        win_o = 2'b00;
        if (req_i == 2'b11) begin
            win_o = ptr_i ? 2'b10 : 2'b01;
        end else begin
            win_o = req_i;
        end
    end

endmodule

// File: rtl/hd44780_bus_sched.sv
// Scheduler sharing one HD44780 8-bit write-only bus between two requesters.
// Enforces the power-up delay, round-robin arbitration, RS/data setup before the
// enable strobe, the enable low pulse and a per-transfer completion wait.
// All state updates happen on the falling edge of the 1 MHz clock.
// Ports:
//   clk, rst         clock (negedge active), synchronous active-high reset
//   req/req_rs       per-requester request and register select
//   req_data         byte of requester i at [8i+7:8i]
//   req_wait         post-pulse wait of requester i at [16i+15:16i]
//   grant/done       one-cycle pulses per requester (accepted / finished)
//   busy             high in every state except IDLE
//   lcd_rs/rw/clk/data  LCD pins (lcd_clk is the enable, idle high)
module hd44780_bus_sched
    import hd44780_bus_sched_pkg::*;
#(
    parameter int unsigned POWERUP_CYC = DEF_POWERUP_CYC,
    parameter int unsigned SETUP_CYC   = DEF_SETUP_CYC,
    parameter int unsigned PULSE_CYC   = DEF_PULSE_CYC,
    parameter int unsigned MIN_WAIT    = DEF_MIN_WAIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  req_rs,
    input  logic [15:0] req_data,
    input  logic [31:0] req_wait,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic        busy,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_clk,
    output logic [7:0]  lcd_data
);

    localparam logic [15:0] PU_LAST    = 16'(POWERUP_CYC - 1);
    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYC - 1);
    localparam logic [15:0] MIN_W      = 16'(MIN_WAIT);

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] wait_q, wait_d;
    logic        owner_q, owner_d;
    logic        ptr_q, ptr_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  done_q, done_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;
    logic        en_q, en_d;

    logic [1:0]  win;
    logic        win_idx;

    hd44780_rr_arb u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .win_o (win)
    );

    assign win_idx = win[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_d = 2'b00;
        done_d  = 2'b00;
        rs_d    = rs_q;
        data_d  = data_q;
        en_d    = en_q;
        case (state_q)
            // Power-up counts up from the reset value 0; transfer phases count down.
            ST_POWERUP: begin
                if (cnt_q == PU_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_IDLE: begin
                if (req != 2'b00) begin
                    grant_d = win;
                    owner_d = win_idx;
                    ptr_d   = ~win_idx;
                    rs_d    = req_rs[win_idx];
                    data_d  = win_idx ? req_data[15:8] : req_data[7:0];
                    wait_d  = wait_floor(win_idx ? req_wait[31:16] : req_wait[15:0], MIN_W);
                    cnt_d   = SETUP_LAST;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_STROBE;
                    en_d    = 1'b0;
                    cnt_d   = PULSE_LAST;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_WAIT;
                    en_d    = 1'b1;
                    cnt_d   = wait_q - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            // done is registered, so it appears in the cycle the bus is already IDLE.
            ST_WAIT: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                    done_d  = owner_q ? 2'b10 : 2'b01;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_POWERUP;
                cnt_d   = 16'd0;
            end
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q <= ST_POWERUP;
            cnt_q   <= 16'd0;
            wait_q  <= 16'd0;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            en_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            en_q    <= en_d;
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign busy     = (state_q != ST_IDLE);
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_clk  = en_q;
    assign lcd_data = data_q;

endmodule

// File: tb/tb_hd44780_bus_sched.sv
// Scoreboard bench for hd44780_bus_sched. A transaction-level reference model
// (runs on the DUT's active falling edge) predicts grants and dones with cycle
// stamps; a monitor on the rising edge pops and compares. Directed sequences
// plus a randomized phase drive the requesters.
module tb_hd44780_bus_sched;

    localparam int PU   = 2000;
    localparam int S    = 1;
    localparam int P    = 2;
    localparam int MINW = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  req_rs = 2'b00;
    logic [15:0] req_data = 16'h0000;
    logic [31:0] req_wait = 32'h0;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic        busy;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_clk;
    logic [7:0]  lcd_data;

    hd44780_bus_sched #(
        .POWERUP_CYC (PU),
        .SETUP_CYC   (S),
        .PULSE_CYC   (P),
        .MIN_WAIT    (MINW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_rs   (req_rs),
        .req_data (req_data),
        .req_wait (req_wait),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_clk  (lcd_clk),
        .lcd_data (lcd_data)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        int         cyc;
        logic       rs;
        logic [7:0] data;
    } exp_t;

    exp_t gq[$];
    exp_t dq[$];

    // Reference model state: n = active edges since reset released.
    int         n = 0;
    int         free_at = PU + 1;
    int         last = 1;
    int         g_last = 0;
    bit         cur_valid = 1'b0;
    bit         started = 1'b0;
    logic       exp_rs = 1'b0;
    logic [7:0] exp_data = 8'h00;

    task automatic cmp(input string nm, input int act, input int req_v);
        checks++;
        if (act != req_v) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req_v);
        end
    endtask

    task automatic fail_msg(input string nm, input int act, input int req_v);
        checks++;
        errors++;
        $display("FAIL %s actual=%0d required=%0d", nm, act, req_v);
    endtask

    function automatic int onehot(input int id);
        return (id != 0) ? 2 : 1;
    endfunction

    function automatic logic [15:0] rand_wait();
        if ($urandom_range(0, 2) == 0) return 16'($urandom_range(0, 45));
        return 16'($urandom_range(40, 90));
    endfunction

    // Model: a transfer is granted on any edge at which the bus is free and someone
    // requests; it occupies S+P+max(wait,MINW) edges, and the next may start one later.
    always @(negedge clk) begin : model
        int   w;
        int   wt;
        exp_t e;
        started = 1'b1;
        if (rst) begin
            n = 0;
            free_at = PU + 1;
            last = 1;
            cur_valid = 1'b0;
            exp_rs = 1'b0;
            exp_data = 8'h00;
            gq.delete();
            dq.delete();
        end else begin
            n++;
            if (n >= free_at && req != 2'b00) begin
                if (req == 2'b11) w = 1 - last;
                else w = req[1] ? 1 : 0;
                wt = (w != 0) ? int'(req_wait[31:16]) : int'(req_wait[15:0]);
                if (wt < MINW) wt = MINW;
                e.id = w;
                e.cyc = n;
                e.rs = req_rs[w];
                e.data = (w != 0) ? req_data[15:8] : req_data[7:0];
                gq.push_back(e);
                e.cyc = n + S + P + wt;
                dq.push_back(e);
                free_at = n + S + P + wt + 1;
                last = w;
                g_last = n;
                cur_valid = 1'b1;
                exp_rs = e.rs;
                exp_data = e.data;
            end
        end
    end

    always @(posedge clk) begin : monitor
        if (started) begin
            cmp("busy", int'(busy), int'(n + 1 < free_at));
            cmp("lcd_clk", int'(lcd_clk),
                int'(!(cur_valid && n >= g_last + S && n < g_last + S + P)));
            cmp("lcd_rs", int'(lcd_rs), int'(exp_rs));
            cmp("lcd_data", int'(lcd_data), int'(exp_data));
            cmp("lcd_rw", int'(lcd_rw), 0);
            cmp("grant_done_overlap", int'(grant != 2'b00 && done != 2'b00), 0);
            while (gq.size() > 0 && gq[0].cyc < n) begin
                fail_msg("grant_missing", 0, onehot(gq[0].id));
                void'(gq.pop_front());
            end
            if (grant != 2'b00) begin
                if (gq.size() > 0 && gq[0].cyc == n) begin
                    cmp("grant_id", int'(grant), onehot(gq[0].id));
                    void'(gq.pop_front());
                end else begin
                    fail_msg("grant_unexpected", int'(grant), 0);
                end
            end
            while (dq.size() > 0 && dq[0].cyc < n) begin
                fail_msg("done_missing", 0, onehot(dq[0].id));
                void'(dq.pop_front());
            end
            if (done != 2'b00) begin
                if (dq.size() > 0 && dq[0].cyc == n) begin
                    cmp("done_id", int'(done), onehot(dq[0].id));
                    void'(dq.pop_front());
                end else begin
                    fail_msg("done_unexpected", int'(done), 0);
                end
            end
        end
    end

    task automatic wait_grant(input int budget, output int gid, output int gcyc);
        gid = -1;
        gcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (grant != 2'b00) begin
                gid = grant[1] ? 1 : 0;
                gcyc = n;
                return;
            end
        end
        fail_msg("grant_timeout", 0, 1);
    endtask

    task automatic wait_done(input int budget, input logic [7:0] xdata, input logic xrs,
                             output int did, output int dcyc, output int low, output int bad);
        did = -1;
        dcyc = -1;
        low = 0;
        bad = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (lcd_clk == 1'b0) low++;
            if (lcd_data !== xdata || lcd_rs !== xrs) bad++;
            if (done != 2'b00) begin
                did = done[1] ? 1 : 0;
                dcyc = n;
                return;
            end
        end
        fail_msg("done_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (busy == 1'b0) return;
        end
        fail_msg("idle_timeout", 1, 0);
    endtask

    initial begin : stim
        int gid, gc, prev, did, dc, low, bad, cnt;
        bit found;
        rst = 1'b1;
        repeat (3) @(posedge clk);

        // Power-up with both requesting, then strict alternation.
        req = 2'b11;
        req_rs = 2'b10;
        req_data = 16'h4138;
        req_wait = {16'd100, 16'd100};
        rst = 1'b0;
        wait_grant(PU + 20, gid, gc);
        cmp("first_grant_cycle", gc, PU + 1);
        cmp("first_grant_id", gid, 0);
        prev = gc;
        for (int k = 1; k < 4; k++) begin
            wait_grant(200, gid, gc);
            cmp("alt_id", gid, k % 2);
            cmp("alt_spacing", gc - prev, 104);
            prev = gc;
        end
        req = 2'b00;
        wait_idle(200);

        // Command write with wait below the floor.
        req = 2'b01;
        req_rs = 2'b00;
        req_data = 16'h0038;
        req_wait = {16'd0, 16'd37};
        wait_grant(10, gid, gc);
        req = 2'b00;
        cmp("cmd_data", int'(lcd_data), 8'h38);
        wait_done(100, 8'h38, 1'b0, did, dc, low, bad);
        cmp("cmd_done_id", did, 0);
        cmp("cmd_done_spacing", dc - gc, 43);
        cmp("cmd_low_cycles", low, 2);
        cmp("cmd_stable", bad, 0);

        // Data write with the largest wait.
        req = 2'b10;
        req_rs = 2'b10;
        req_data = 16'h4100;
        req_wait = {16'hFFFF, 16'd0};
        wait_grant(10, gid, gc);
        req = 2'b00;
        cmp("max_grant_id", gid, 1);
        wait_done(70000, 8'h41, 1'b1, did, dc, low, bad);
        cmp("max_done_id", did, 1);
        cmp("max_done_spacing", dc - gc, 65538);
        cmp("max_low_cycles", low, 2);
        cmp("max_stable", bad, 0);

        // Randomized requesters.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            if ($urandom_range(0, 3) == 0) begin
                req = 2'($urandom_range(0, 3));
                req_rs = 2'($urandom);
                req_data = 16'($urandom);
                req_wait = {rand_wait(), rand_wait()};
            end
        end
        req = 2'b00;
        wait_idle(300);

        // Requester 0 pulses during requester 1's wait and gives up.
        req = 2'b10;
        req_rs = 2'b00;
        req_data = 16'h5A3C;
        req_wait = {16'd50, 16'd50};
        wait_grant(10, gid, gc);
        req = 2'b00;
        cmp("pulse_owner_id", gid, 1);
        repeat (10) @(posedge clk);
        req = 2'b01;
        @(posedge clk);
        req = 2'b00;
        wait_done(200, 8'h5A, 1'b0, did, dc, low, bad);
        cmp("pulse_done_id", did, 1);
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            if (grant != 2'b00) cnt++;
        end
        cmp("dropped_req_grants", cnt, 0);

        // Reset in the middle of the enable pulse.
        req = 2'b01;
        req_rs = 2'b01;
        req_data = 16'h00A5;
        req_wait = {16'd0, 16'd60};
        wait_grant(10, gid, gc);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(posedge clk);
            if (lcd_clk == 1'b0) found = 1'b1;
        end
        cmp("strobe_seen", int'(found), 1);
        rst = 1'b1;
        @(posedge clk);
        cmp("rst_lcd_clk", int'(lcd_clk), 1);
        cmp("rst_lcd_data", int'(lcd_data), 0);
        cmp("rst_lcd_rs", int'(lcd_rs), 0);
        cmp("rst_busy", int'(busy), 1);
        cmp("rst_grant", int'(grant), 0);
        cmp("rst_done", int'(done), 0);
        rst = 1'b0;
        wait_grant(PU + 20, gid, gc);
        cmp("regrant_cycle", gc, PU + 1);
        cmp("regrant_id", gid, 0);
        req = 2'b00;
        wait_idle(100);

        repeat (5) @(posedge clk);
        cmp("queues_drained", gq.size() + dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
